// File: rtl/temp_disp_pkg.sv
// Shared types, digit codes and segment patterns for the temperature display.
// Provides the FSM state enum, 4-bit digit code type and seg_decode().
package temp_disp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SHIFT   = 2'd2,
      DONE    = 2'd3
   } disp_state_t;

   typedef logic [3:0] digit_t;

   localparam digit_t DIG_BLANK = 4'hA;
   localparam digit_t DIG_MINUS = 4'hB;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   localparam int SHIFT_CYCLES = 14;

   // Active-low pattern, bit 0 = segment a ... bit 6 = segment g.
   function automatic logic [6:0] seg_decode(input digit_t d);
      logic [6:0] s;
      unique case (d)
         4'd0:      s = 7'h40;
         4'd1:      s = 7'h79;
         4'd2:      s = 7'h24;
         4'd3:      s = 7'h30;
         4'd4:      s = 7'h19;
         4'd5:      s = 7'h12;
         4'd6:      s = 7'h02;
         4'd7:      s = 7'h78;
         4'd8:      s = 7'h00;
         4'd9:      s = 7'h10;
         DIG_MINUS: s = SEG_MINUS;
         default:   s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_dabble.sv
// Sequential double-dabble: 14-bit binary magnitude to four BCD nibbles.
// Ports: clk, rst_n, start_i (loads mag_i), mag_i[13:0], bcd_o[15:0], done_o.
module bcd_dabble
   import temp_disp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [13:0] mag_i,
   output logic [15:0] bcd_o,
   output logic        done_o
);

   logic [29:0] sr_q, sr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        run_q, run_d;
   logic [15:0] bcd_adj;
   logic        last;

   assign last = run_q && (cnt_q == 4'(SHIFT_CYCLES - 1));

   always_comb begin
      bcd_adj = sr_q[29:14];
      for (int i = 0; i < 4; i++) begin
         if (sr_q[14 + i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = sr_q[14 + i*4 +: 4] + 4'd3;
      end
   end

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (start_i) begin
         sr_d  = {16'h0000, mag_i};
         cnt_d = 4'd0;
         run_d = 1'b1;
      end else if (run_q) begin
         sr_d  = {bcd_adj[14:0], sr_q[13:0], 1'b0};
         cnt_d = cnt_q + 4'd1;
         run_d = !last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign bcd_o  = sr_q[29:14];
   assign done_o = last;

endmodule

// File: rtl/temp_seg_display.sv
// Shows the selected signed temperature on a 4-digit active-low 7-seg display.
// Ports: clk, rst_n, c_in, f_in, unit_sel in; seg, dp, an, busy out.
module temp_seg_display
   import temp_disp_pkg::*;
#(
   parameter int UPDATE_DIV  = 1_000_000,
   parameter int REFRESH_DIV = 100_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] c_in,
   input  logic [15:0] f_in,
   input  logic        unit_sel,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        busy
);

   localparam int UW = $clog2(UPDATE_DIV);
   localparam int RW = $clog2(REFRESH_DIV);

   disp_state_t state_q, state_d;

   logic [UW-1:0] upd_q, upd_d;
   logic [RW-1:0] ref_q, ref_d;
   logic          upd_wrap, ref_wrap;
   logic [1:0]    idx_q, idx_d;

   logic          neg_q, neg_d;
   logic          ovf_q, ovf_d;

   logic [15:0]   v;
   logic [16:0]   mag;
   logic [3:0][3:0] bcd;
   logic          dab_done;

   digit_t [3:0]  dig_q, dig_d, fmt;
   logic [1:0]    msd;

   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;

   // ---- counters ----
   assign upd_wrap = (upd_q == UW'(UPDATE_DIV - 1));
   assign ref_wrap = (ref_q == RW'(REFRESH_DIV - 1));

   always_comb begin
      upd_d = upd_wrap ? '0 : upd_q + UW'(1);
      ref_d = ref_wrap ? '0 : ref_q + RW'(1);
      idx_d = idx_q + {1'b0, ref_wrap};
   end

   // ---- capture ----
   assign v   = unit_sel ? f_in : c_in;
   // 17 bits so that |-32768| is representable and flagged as overflow.
   assign mag = v[15] ? ({1'b0, ~v} + 17'd1) : {1'b0, v};

   bcd_dabble u_dabble (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (state_q == CAPTURE),
      .mag_i   (mag[13:0]),
      .bcd_o   (bcd),
      .done_o  (dab_done)
   );

   // ---- FSM ----
   always_comb begin
      state_d = state_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE:    if (upd_wrap) state_d = CAPTURE;
         CAPTURE: begin
            state_d = SHIFT;
            neg_d   = v[15];
            ovf_d   = (mag > 17'd9999) || (v[15] && mag > 17'd999);
         end
         SHIFT:   if (dab_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---- formatter ----
   always_comb begin
      msd = 2'd0;
      for (int i = 1; i < 4; i++) begin
         if (bcd[i] != 4'd0) msd = 2'(i);
      end
      for (int i = 0; i < 4; i++) begin
         if (ovf_q)
            fmt[i] = DIG_MINUS;
         else if (i > int'(msd))
            fmt[i] = (neg_q && i == int'(msd) + 1) ? DIG_MINUS : DIG_BLANK;
         else
            fmt[i] = bcd[i];
      end
   end

   // Digits, anode and cathodes are all taken from next-state values so a
   // digit update coinciding with a scan step is visible at once.
   always_comb begin
      dig_d = dig_q;
      if (state_q == DONE) dig_d = fmt;
      an_d  = ~(4'b0001 << idx_d);
      seg_d = seg_decode(dig_d[idx_d]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         upd_q   <= '0;
         ref_q   <= '0;
         idx_q   <= 2'd0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         dig_q   <= {4{DIG_BLANK}};
         seg_q   <= SEG_BLANK;
         an_q    <= 4'b1111;
      end else begin
         state_q <= state_d;
         upd_q   <= upd_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
         dig_q   <= dig_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign dp   = 1'b1;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_temp_seg_display.sv
// Directed self-checking bench for temp_seg_display.
// Small dividers; samples on the falling clock edge.
module tb_temp_seg_display;

   localparam logic [6:0] S0 = 7'h40;
   localparam logic [6:0] S1 = 7'h79;
   localparam logic [6:0] S2 = 7'h24;
   localparam logic [6:0] S3 = 7'h30;
   localparam logic [6:0] S4 = 7'h19;
   localparam logic [6:0] S5 = 7'h12;
   localparam logic [6:0] S9 = 7'h10;
   localparam logic [6:0] SB = 7'h7F;
   localparam logic [6:0] SM = 7'h3F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] c_in, f_in;
   logic        unit_sel;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        busy;

   int checks = 0;
   int failures = 0;

   temp_seg_display #(
      .UPDATE_DIV  (64),
      .REFRESH_DIV (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .c_in     (c_in),
      .f_in     (f_in),
      .unit_sel (unit_sel),
      .seg      (seg),
      .dp       (dp),
      .an       (an),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic conv_wait(input string tag);
      logic prev;
      bit   seen;
      prev = busy;
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         if (busy && !prev) seen = 1'b1;
         prev = busy;
      end
      chk({tag, "_start"}, 32'(seen), 32'd1);
   endtask

   task automatic busy_len(input string tag, input int start);
      int len;
      len = start;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (!busy) break;
         len++;
      end
      chk({tag, "_busy"}, len, 32'd16);
   endtask

   task automatic check_disp(input string tag, input logic [6:0] e3,
                             input logic [6:0] e2, input logic [6:0] e1,
                             input logic [6:0] e0);
      logic [6:0] got [4];
      int bad;
      bad = 0;
      for (int i = 0; i < 4; i++) got[i] = 7'h55;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         if (dp !== 1'b1) bad++;
         case (an)
            4'b1110: got[0] = seg;
            4'b1101: got[1] = seg;
            4'b1011: got[2] = seg;
            4'b0111: got[3] = seg;
            default: bad++;
         endcase
      end
      chk({tag, "_an"}, bad, 32'd0);
      chk({tag, "_d3"}, 32'(got[3]), 32'(e3));
      chk({tag, "_d2"}, 32'(got[2]), 32'(e2));
      chk({tag, "_d1"}, 32'(got[1]), 32'(e1));
      chk({tag, "_d0"}, 32'(got[0]), 32'(e0));
   endtask

   task automatic convert(input string tag, input logic us,
                          input logic [15:0] c, input logic [15:0] f,
                          input logic [6:0] e3, input logic [6:0] e2,
                          input logic [6:0] e1, input logic [6:0] e0);
      unit_sel = us;
      c_in     = c;
      f_in     = f;
      conv_wait(tag);
      busy_len(tag, 1);
      check_disp(tag, e3, e2, e1, e0);
   endtask

   initial begin
      logic [3:0] prev_an;
      logic [3:0] exp_an;
      bit         found;

      rst_n    = 1'b0;
      c_in     = 16'd0;
      f_in     = 16'd0;
      unit_sel = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_an", 32'(an), 32'h0F);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dp", 32'(dp), 32'd1);
      rst_n = 1'b1;

      // Scan order and dwell time, from a 3->0 transition.
      prev_an = an;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         @(negedge clk);
         if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
         prev_an = an;
      end
      chk("scan_sync", 32'(found), 32'd1);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp_an = ~(4'b0001 << ((k / 4) % 4));
         chk($sformatf("scan_%0d", k), 32'(an), 32'(exp_an));
      end
      chk("scan_dp", 32'(dp), 32'd1);

      convert("c23", 1'b0, 16'd23, 16'd0, SB, SB, S2, S3);
      convert("fm40", 1'b1, 16'd0, 16'hFFD8, SB, SM, S4, S0);
      convert("c0", 1'b0, 16'd0, 16'd0, SB, SB, SB, S0);
      convert("c9999", 1'b0, 16'd9999, 16'd0, S9, S9, S9, S9);
      convert("c10000", 1'b0, 16'd10000, 16'd0, SM, SM, SM, SM);
      convert("cm999", 1'b0, 16'hFC19, 16'd0, SM, S9, S9, S9);
      convert("cm1000", 1'b0, 16'hFC18, 16'd0, SM, SM, SM, SM);
      convert("c8000", 1'b0, 16'h8000, 16'd0, SM, SM, SM, SM);
      convert("cm5", 1'b0, 16'hFFFB, 16'd0, SB, SB, SM, S5);

      // Inputs change during SHIFT; the latched value must be shown.
      unit_sel = 1'b0;
      c_in     = 16'd123;
      f_in     = 16'd55;
      conv_wait("latch");
      repeat (3) @(negedge clk);
      unit_sel = 1'b1;
      c_in     = 16'd7;
      busy_len("latch", 4);
      check_disp("latch", SB, S1, S2, S3);

      // Reset in the middle of SHIFT aborts without a display update.
      unit_sel = 1'b0;
      c_in     = 16'd4444;
      conv_wait("abort");
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_an", 32'(an), 32'h0F);
      chk("abort_seg", 32'(seg), 32'h7F);
      chk("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check_disp("abort", SB, SB, SB, SB);
      chk("abort_busy2", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
